uart_tx_param: RTL

Parametrised UART serial transmitter that replaces the fixed 7-bit, one-bit-per-clock transmitter.
- Configurable data width, parity mode, stop-bit count and baud divider.
- Ready/valid input handshake, with an optional one-entry holding buffer for gap-free frames.
- Sits between a byte-stream producer (CPU bridge or test pattern source) and the board's TX pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_tx_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity mode encodings
//   state_t                   : transmit FSM states
//   frame_bits()              : serial bits per frame (start + data + parity + stop)
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Number of serial bit periods in one complete frame.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 and flags the last
// cycle of every bit period. restart_i forces the count back to 0 so a new
// frame always begins on a full bit period.
//   sys_clk   : clock, rising edge
//   reset     : asynchronous, active-high reset
//   restart_i : restart the bit period on the next edge
//   tick_o    : high during the final cycle of each bit period
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count; tick is registered so it lines up with cnt_q == last.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with ready/valid input.
// Frame: START(0), DATA_BITS data LSB first, optional parity, STOP_BITS ones.
// Optional one-entry holding buffer for gap-free frames: define UART_TX_SKID_EN.
//   sys_clk  : clock, rising edge
//   reset    : asynchronous, active-high reset
//   in_valid : producer offers in_data
//   in_ready : a word is accepted on an edge with in_valid && in_ready
//   in_data  : payload word
//   tx       : registered serial output, idles high
//   busy     : high while a frame is on the line
//   done     : one-cycle pulse in the last cycle of the final stop bit
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BIT_W      = 4;
    localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);

    // Reject illegal configurations at elaboration.
    if (PARITY_MODE > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE=%0d is illegal", PARITY_MODE);
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS=%0d out of range 5..9", DATA_BITS);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT=%0d must be >= 2", CLKS_PER_BIT);
    end
    if (FRAME_BITS < 7 || FRAME_BITS > 13) begin : g_bad_frame
        $error("uart_tx_param: frame of %0d bits is not supported", FRAME_BITS);
    end

    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 in_ready_q, in_ready_d;

    logic                 accept_c;
    logic                 load_en_c;
    logic [DATA_BITS-1:0] load_data_c;
    logic                 baud_tick;

`ifdef UART_TX_SKID_EN
    logic                 buf_valid_q, buf_valid_d;
    logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
`endif

    assign accept_c = in_valid && in_ready_q;

    // Bit-period timing; restarted whenever a new frame is loaded.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .restart_i (load_en_c),
        .tick_o    (baud_tick)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        load_en_c   = 1'b0;
        load_data_c = in_data;
        done_d      = 1'b0;
`ifdef UART_TX_SKID_EN
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    load_en_c = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef UART_TX_SKID_EN
                        // Buffered word goes straight to START, no idle gap.
                        if (buf_valid_q) begin
                            load_en_c   = 1'b1;
                            load_data_c = buf_data_q;
                            buf_valid_d = 1'b0;
                        end
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Latch a new frame; parity comes from the latched word only.
        if (load_en_c) begin
            state_d   = START;
            bit_cnt_d = '0;
            shift_d   = load_data_c;
            par_d     = (PARITY_MODE == PAR_ODD) ? ~(^load_data_c) : (^load_data_c);
        end

`ifdef UART_TX_SKID_EN
        // Words accepted mid-frame park in the buffer; IDLE accepts bypass it.
        if (accept_c && (state_q != IDLE)) begin
            buf_valid_d = 1'b1;
            buf_data_d  = in_data;
        end
        in_ready_d = ~buf_valid_d;
`else
        in_ready_d = (state_d == IDLE);
`endif

        // Line level follows the current state one cycle later.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef UART_TX_SKID_EN
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;

endmodule
